// File: rtl/conv_window_gen_if.sv
// Handshake/bus bundle for conv_window_gen: frame control, BRAM read port and the PE window port.
// master = controller/PE/BRAM side, slave = the window generator.
interface conv_window_gen_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 64
);
  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic                  busy;
  logic                  done;
  logic                  bram_en;
  logic [ADDR_W-1:0]     bram_addr;
  logic [DATA_W-1:0]     bram_dout;
  logic [9*DATA_W-1:0]   win_data;
  logic                  win_valid;
  logic                  win_ready;
  logic [7:0]            win_row;
  logic [7:0]            win_col;

  modport master (
    output start, base_addr, bram_dout, win_ready,
    input  busy, done, bram_en, bram_addr, win_data, win_valid, win_row, win_col
  );

  modport slave (
    input  start, base_addr, bram_dout, win_ready,
    output busy, done, bram_en, bram_addr, win_data, win_valid, win_row, win_col
  );
endinterface

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: streams a feature map from BRAM through two line buffers.
// Define STRIDE2_EN to emit only windows at even (row, col).
module conv_window_gen #(
  parameter int unsigned IMG_W  = 16,
  parameter int unsigned IMG_H  = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 64
) (
  input logic              clk,
  input logic              rst,
  conv_window_gen_if.slave bus
);

  localparam int unsigned ColW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [7:0]  LastCol = 8'(IMG_W - 1);
  localparam logic [7:0]  LastRow = 8'(IMG_H - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic [7:0]          pr_q, pr_d, pc_q, pc_d;
  logic                rvalid_q, rvalid_d;
  logic                pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic                proc_done_q, proc_done_d;
  logic                win_valid_q, win_valid_d;
  logic [9*DATA_W-1:0] win_data_q, win_data_d;
  logic [7:0]          win_row_q, win_row_d, win_col_q, win_col_d;

  logic [DATA_W-1:0]   lb0_q [IMG_W];
  logic [DATA_W-1:0]   lb1_q [IMG_W];
  logic [DATA_W-1:0]   win_q [9];
  logic [DATA_W-1:0]   win_n [9];

  logic              stall, start_acc, issue, last_read, proc, emit, stride_ok;
  logic [DATA_W-1:0] word;
  logic [ColW-1:0]   lb_idx;

`ifdef STRIDE2_EN
  assign stride_ok = ~pr_q[0] & ~pc_q[0];
`else
  assign stride_ok = 1'b1;
`endif

  assign stall     = win_valid_q & ~bus.win_ready;
  assign start_acc = (state_q == StIdle) & bus.start;
  assign issue     = (state_q == StRun) & ~stall & ~pend_valid_q;
  assign last_read = (rd_row_q == LastRow) & (rd_col_q == LastCol);
  // Pending data always wins over a fresh return; both are never present together.
  assign proc      = ~stall & (pend_valid_q | rvalid_q);
  assign word      = pend_valid_q ? pend_data_q : bus.bram_dout;
  assign lb_idx    = pc_q[ColW-1:0];
  assign emit      = proc & (pr_q >= 8'd2) & (pc_q >= 8'd2) & stride_ok;

  // Window after the shift: element 3*i+j is row i, column j.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_n[3*i]   = win_q[3*i+1];
      win_n[3*i+1] = win_q[3*i+2];
    end
    win_n[2] = lb0_q[lb_idx];
    win_n[5] = lb1_q[lb_idx];
    win_n[8] = word;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_row_d     = rd_row_q;
    rd_col_d     = rd_col_q;
    pr_d         = pr_q;
    pc_d         = pc_q;
    rvalid_d     = issue;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    proc_done_d  = proc_done_q;
    win_valid_d  = win_valid_q;
    win_data_d   = win_data_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;

    case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (issue && last_read) state_d = StDrain;
      StDrain: if (proc_done_q && (!win_valid_q || bus.win_ready)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (start_acc) begin
      addr_d      = bus.base_addr;
      rd_row_d    = '0;
      rd_col_d    = '0;
      pr_d        = '0;
      pc_d        = '0;
      proc_done_d = 1'b0;
    end

    if (issue) begin
      addr_d = addr_q + 1'b1;
      if (rd_col_q == LastCol) begin
        rd_col_d = '0;
        rd_row_d = rd_row_q + 8'd1;
      end else begin
        rd_col_d = rd_col_q + 8'd1;
      end
    end

    if (stall && rvalid_q) begin
      pend_valid_d = 1'b1;
      pend_data_d  = bus.bram_dout;
    end else if (proc && pend_valid_q) begin
      pend_valid_d = 1'b0;
    end

    if (proc) begin
      if (pc_q == LastCol) begin
        pc_d = '0;
        pr_d = pr_q + 8'd1;
        if (pr_q == LastRow) proc_done_d = 1'b1;
      end else begin
        pc_d = pc_q + 8'd1;
      end
    end

    if (emit) begin
      win_valid_d = 1'b1;
      win_row_d   = pr_q - 8'd2;
      win_col_d   = pc_q - 8'd2;
      for (int k = 0; k < 9; k++) win_data_d[DATA_W*k +: DATA_W] = win_n[k];
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      pr_q         <= '0;
      pc_q         <= '0;
      rvalid_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      proc_done_q  <= 1'b0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_row_q     <= rd_row_d;
      rd_col_q     <= rd_col_d;
      pr_q         <= pr_d;
      pc_q         <= pc_d;
      rvalid_q     <= rvalid_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      proc_done_q  <= proc_done_d;
      win_valid_q  <= win_valid_d;
      win_data_q   <= win_data_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
    end
  end

  // Line buffers and the shift window hold only frame data, so they carry no reset.
  always_ff @(posedge clk) begin
    if (proc) begin
      for (int k = 0; k < 9; k++) win_q[k] <= win_n[k];
      lb0_q[lb_idx] <= lb1_q[lb_idx];
      lb1_q[lb_idx] <= word;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.bram_en   = issue;
  assign bus.bram_addr = addr_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_data  = win_data_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a small frame DUT and a 16x16 DUT, BRAM word = address.
module tb_conv_window_gen;
`ifdef STRIDE2_EN
  localparam int SW = 6;
`else
  localparam int SW = 4;
`endif
  localparam int LW = 16;
  localparam int AW = 12;
  localparam int DW = 64;

  typedef struct packed {
    int          er;
    int          ec;
    int          cnt;
    int          dones;
    logic [11:0] base;
    logic [11:0] eaddr;
    logic        prev_stall;
    logic        prev_acc;
    logic [575:0] prev_data;
    logic [7:0]  prev_row;
    logic [7:0]  prev_col;
  } mon_t;

  logic clk = 1'b0;
  logic rst_s, rst_l;
  int   checks = 0;
  int   errors = 0;
  mon_t s_m, l_m;
  logic [3:0] pat = 4'b1001;
  int   first_w [9];

  always #5 clk = ~clk;

  conv_window_gen_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();
  conv_window_gen_if #(.ADDR_W(AW), .DATA_W(DW)) l_if ();

  conv_window_gen #(.IMG_W(SW), .IMG_H(SW), .ADDR_W(AW), .DATA_W(DW)) u_s (
    .clk (clk),
    .rst (rst_s),
    .bus (s_if.slave)
  );

  conv_window_gen #(.IMG_W(LW), .IMG_H(LW), .ADDR_W(AW), .DATA_W(DW)) u_l (
    .clk (clk),
    .rst (rst_l),
    .bus (l_if.slave)
  );

  always @(posedge clk) if (s_if.bram_en) s_if.bram_dout <= 64'(s_if.bram_addr);
  always @(posedge clk) if (l_if.bram_en) l_if.bram_dout <= 64'(l_if.bram_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit emit_ok(input int r, input int c);
`ifdef STRIDE2_EN
    return (r % 2 == 0) && (c % 2 == 0);
`else
    return (r >= 0) && (c >= 0);
`endif
  endfunction

  task automatic mon_step(input string id, input int w, input logic r, input logic start,
                          input logic busy, input logic done, input logic en,
                          input logic [11:0] addr, input logic [11:0] base_in,
                          input logic valid, input logic ready, input logic [575:0] data,
                          input logic [7:0] row, input logic [7:0] col, inout mon_t m);
    logic [11:0] a;
    if (r) begin
      m.prev_stall = 1'b0;
      m.prev_acc   = 1'b0;
      return;
    end
    if (start && !busy) begin
      m.er = 0; m.ec = 0; m.cnt = 0; m.dones = 0;
      m.base = base_in; m.eaddr = base_in;
    end
    if (m.prev_stall) begin
      chk({id, "_hold_valid"}, 64'(valid), 64'd1);
      chk({id, "_hold_data"}, {63'd0, data === m.prev_data}, 64'd1);
      chk({id, "_hold_row"}, 64'(row), 64'(m.prev_row));
      chk({id, "_hold_col"}, 64'(col), 64'(m.prev_col));
    end
    if (valid && !ready) chk({id, "_en_in_stall"}, 64'(en), 64'd0);
    if (en) begin
      chk({id, "_bram_addr"}, 64'(addr), 64'(m.eaddr));
      m.eaddr = m.eaddr + 12'd1;
    end
    if (valid && ready) begin
      chk({id, "_win_row"}, 64'(row), 64'(m.er));
      chk({id, "_win_col"}, 64'(col), 64'(m.ec));
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          a = m.base + 12'((m.er + i) * w + m.ec + j);
          chk($sformatf("%s_win_px%0d%0d", id, i, j), data[64*(3*i+j) +: 64], {52'd0, a});
        end
      end
      m.cnt++;
      do begin
        m.ec++;
        if (m.ec > w - 3) begin
          m.ec = 0;
          m.er++;
        end
      end while (!emit_ok(m.er, m.ec));
    end
    if (done) begin
`ifndef STRIDE2_EN
      chk({id, "_done_after_accept"}, 64'(m.prev_acc), 64'd1);
`endif
      m.dones++;
    end
    m.prev_acc   = valid && ready;
    m.prev_stall = valid && !ready;
    m.prev_data  = data;
    m.prev_row   = row;
    m.prev_col   = col;
  endtask

  // One clock cycle: monitors sample at the falling edge, caller drives after the rising edge.
  task automatic tick();
    @(negedge clk);
    mon_step("s", SW, rst_s, s_if.start, s_if.busy, s_if.done, s_if.bram_en, s_if.bram_addr,
             s_if.base_addr, s_if.win_valid, s_if.win_ready, s_if.win_data, s_if.win_row,
             s_if.win_col, s_m);
    mon_step("l", LW, rst_l, l_if.start, l_if.busy, l_if.done, l_if.bram_en, l_if.bram_addr,
             l_if.base_addr, l_if.win_valid, l_if.win_ready, l_if.win_data, l_if.win_row,
             l_if.win_col, l_m);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string id, input logic busy, input logic done, input logic en,
                          input logic [11:0] addr, input logic valid, input logic [575:0] data,
                          input logic [7:0] row, input logic [7:0] col);
    chk({id, "_rst_busy"}, 64'(busy), 64'd0);
    chk({id, "_rst_done"}, 64'(done), 64'd0);
    chk({id, "_rst_bram_en"}, 64'(en), 64'd0);
    chk({id, "_rst_bram_addr"}, 64'(addr), 64'd0);
    chk({id, "_rst_win_valid"}, 64'(valid), 64'd0);
    chk({id, "_rst_win_data"}, {63'd0, data === 576'd0}, 64'd1);
    chk({id, "_rst_win_row"}, 64'(row), 64'd0);
    chk({id, "_rst_win_col"}, 64'(col), 64'd0);
  endtask

  // Runs one frame on the small DUT; edges are counted from the start cycle (edge 1 samples it).
  task automatic run_frame(input logic [11:0] base, input bit toggle, input bit poke,
                           output int first_edge, output int done_edge,
                           output logic [575:0] first_data, output logic [11:0] first_addr,
                           output logic first_en);
    s_if.base_addr = base;
    s_if.win_ready = 1'b1;
    s_if.start     = 1'b1;
    tick();
    s_if.start = 1'b0;
    first_addr = s_if.bram_addr;
    first_en   = s_if.bram_en;
    first_edge = 0;
    done_edge  = 0;
    first_data = '0;
    for (int n = 1; n <= 400; n++) begin
      if (s_if.win_valid && first_edge == 0) begin
        first_edge = n;
        first_data = s_if.win_data;
      end
      if (s_if.done) begin
        done_edge = n;
        break;
      end
      if (poke && (n == 5 || n == 12)) begin
        s_if.start     = 1'b1;
        s_if.base_addr = 12'h555;
      end else begin
        s_if.start = 1'b0;
      end
      s_if.win_ready = toggle ? pat[n % 4] : 1'b1;
      tick();
    end
    s_if.start     = 1'b0;
    s_if.win_ready = 1'b1;
    tick();
  endtask

  initial begin
    int fe, de;
    logic [575:0] fd;
    logic [11:0]  fa;
    logic         fen;
    int           ldone;

`ifdef STRIDE2_EN
    first_w = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
`else
    first_w = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
`endif
    s_m = '0;
    l_m = '0;
    rst_s = 1'b1;
    rst_l = 1'b1;
    s_if.start = 1'b0; s_if.base_addr = '0; s_if.win_ready = 1'b0;
    l_if.start = 1'b0; l_if.base_addr = '0; l_if.win_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("s", s_if.busy, s_if.done, s_if.bram_en, s_if.bram_addr, s_if.win_valid,
             s_if.win_data, s_if.win_row, s_if.win_col);
    chk_idle("l", l_if.busy, l_if.done, l_if.bram_en, l_if.bram_addr, l_if.win_valid,
             l_if.win_data, l_if.win_row, l_if.win_col);
    rst_s = 1'b0;
    rst_l = 1'b0;
    tick();

    // Plain frame, ready always high.
    run_frame(12'h000, 1'b0, 1'b0, fe, de, fd, fa, fen);
    chk("a_first_read_en", 64'(fen), 64'd1);
    chk("a_first_read_addr", 64'(fa), 64'h000);
    chk("a_first_latency", 64'(fe), 64'(2 * SW + 5));
    for (int k = 0; k < 9; k++)
      chk($sformatf("a_first_w%0d", k), fd[64*k +: 64], 64'(first_w[k]));
    chk("a_done_edge", 64'(de), 64'(SW * SW + 3));
    chk("a_win_count", 64'(s_m.cnt), 64'd4);
    chk("a_done_pulses", 64'(s_m.dones), 64'd1);
    chk("a_busy_after_done", 64'(s_if.busy), 64'd0);
    chk("a_done_one_cycle", 64'(s_if.done), 64'd0);

    // Ready toggling 1,0,0,1: nothing lost, duplicated or corrupted.
    run_frame(12'h000, 1'b1, 1'b0, fe, de, fd, fa, fen);
    chk("b_done_seen", 64'(de != 0), 64'd1);
    chk("b_win_count", 64'(s_m.cnt), 64'd4);
    chk("b_done_pulses", 64'(s_m.dones), 64'd1);
    chk("b_busy_after_done", 64'(s_if.busy), 64'd0);

    // Base near the top of the address space wraps to 0x000.
    run_frame(12'hFFE, 1'b0, 1'b0, fe, de, fd, fa, fen);
    chk("c_first_read_addr", 64'(fa), 64'hFFE);
    chk("c_first_px00", fd[63:0], 64'hFFE);
    chk("c_first_px02", fd[191:128], 64'h000);
    chk("c_win_count", 64'(s_m.cnt), 64'd4);
    chk("c_done_edge", 64'(de), 64'(SW * SW + 3));

    // Extra start pulses while busy are ignored.
    run_frame(12'h100, 1'b0, 1'b1, fe, de, fd, fa, fen);
    chk("d_first_px00", fd[63:0], 64'h100);
    chk("d_done_edge", 64'(de), 64'(SW * SW + 3));
    chk("d_win_count", 64'(s_m.cnt), 64'd4);
    chk("d_done_pulses", 64'(s_m.dones), 64'd1);

    // 16x16 frame aborted by reset at cycle 10, then a full frame.
    l_if.base_addr = 12'h000;
    l_if.win_ready = 1'b1;
    l_if.start     = 1'b1;
    tick();
    l_if.start = 1'b0;
    repeat (9) tick();
    chk("e_busy_before_rst", 64'(l_if.busy), 64'd1);
    rst_l = 1'b1;
    #1;
    chk_idle("e", l_if.busy, l_if.done, l_if.bram_en, l_if.bram_addr, l_if.win_valid,
             l_if.win_data, l_if.win_row, l_if.win_col);
    repeat (3) tick();
    rst_l = 1'b0;
    repeat (5) tick();
    chk("e_no_done_after_abort", 64'(l_m.dones), 64'd0);
    chk("e_idle_after_abort", 64'(l_if.busy), 64'd0);
    l_if.start = 1'b1;
    tick();
    l_if.start = 1'b0;
    ldone = 0;
    for (int n = 1; n <= 600; n++) begin
      if (l_if.done) begin
        ldone = n;
        break;
      end
      tick();
    end
    tick();
    chk("e_done_edge", 64'(ldone), 64'(LW * LW + 3));
`ifdef STRIDE2_EN
    chk("e_win_count", 64'(l_m.cnt), 64'd49);
`else
    chk("e_win_count", 64'(l_m.cnt), 64'd196);
`endif
    chk("e_done_pulses", 64'(l_m.dones), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Feeds the PE array. Streams a feature map out of a 64-bit feature BRAM (BRAM32k/BRAM4k port, 1-cycle read latency).
- Builds 3x3 sliding windows with two on-chip line buffers and a 3x3 register window.
- Presents each window to the PE with a valid/ready handshake.
- One BRAM word is one pixel position holding 8 channels x 8 bits.

Parameters:
IMG_W, 16, feature-map width in pixels (>=3)
IMG_H, 16, feature-map height in pixels (>=3)
ADDR_W, 12, BRAM address width
DATA_W, 64, BRAM word width (8 ch x 8 b)

Ports:
clk  in  1  system clock (clk_wiz_0 output)
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse; begins a frame when idle
base_addr  in  ADDR_W  BRAM address of pixel (0,0); sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last window accepted
bram_en  out  1  BRAM read enable
bram_addr  out  ADDR_W  read address = base_addr + row*IMG_W + col
bram_dout  in  DATA_W  read data, valid the cycle after bram_en
win_data  out  9*DATA_W  3x3 window, packed as described below
win_valid  out  1  window valid
win_ready  in  1  PE accepts window
win_row  out  8  output-row index of the window (top-left pixel row)
win_col  out  8  output-column index of the window (top-left pixel column)

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, bram_en, win_valid = 0; bram_addr, win_data, win_row, win_col = 0; counters and pending register cleared.
- Line buffers are not cleared.
- Reset mid-frame aborts the frame. No done pulse. The next start begins a fresh frame.
- FSM states:
  - IDLE: start=1 -> RUN; latch base_addr; read row/col = 0.
  - RUN: issue reads in raster order. Last read (IMG_H-1, IMG_W-1) issued -> DRAIN.
  - DRAIN: wait until the final returned word is processed and the last window is accepted -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start is ignored outside IDLE.
- Stall = win_valid & ~win_ready.
- In RUN, a read is issued in cycle t iff there is no stall in t and the pending register is empty. At most one read is outstanding.
- Data returning while stalled is held in a 1-entry pending register. Pending data is consumed before any new read is issued.
- Shift step, per processed word at pixel (r,c):
  - 3x3 window column shifts left.
  - New right column = {linebuf0[c], linebuf1[c], word}.
  - Then linebuf0[c] <= linebuf1[c] and linebuf1[c] <= word.
- Window emission: after processing pixel (r,c) with r>=2 and c>=2, the output register loads and win_valid=1 next cycle.
  - win_row = r-2, win_col = c-2.
  - Output order is raster.
- Packing: win_data[DATA_W*(3*i+j) +: DATA_W] = pixel(win_row+i, win_col+j), for i,j in 0..2.
- win_valid stays high and win_data/win_row/win_col hold stable until win_ready=1 in the same cycle.
- When win_ready=1 with no new window pending, win_valid drops next cycle.
- Window count per frame = (IMG_H-2)*(IMG_W-2), valid convolution, no padding.
- Columns 0..1 of every row only prime the window; no emission.
- Column wrap: read col wraps IMG_W-1 -> 0, row increments.
- Throughput: 1 window/cycle in steady state with win_ready held high.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).
- Latency: first window valid 2*IMG_W+3+2 cycles after start when never stalled.

Optional Feature:
STRIDE2_EN
- Defined: emit only windows with even win_row and even win_col. Count = floor((IMG_H-1)/2)*floor((IMG_W-1)/2).
- Defined: reads and line-buffer updates are unchanged; win_row/win_col keep full-resolution indices.
- Undefined: stride 1 as above.

Test Plan:
- IMG_W=IMG_H=4, base_addr=0, word=address, win_ready=1, start pulse:
  - 4 windows, (row,col)=(0,0),(0,1),(1,0),(1,1).
  - First window words = 0,1,2,4,5,6,8,9,10.
  - Last window = 5,6,7,9,10,11,13,14,15.
  - done one cycle after 4th accept; busy then 0.
- Same frame with win_ready toggling 1,0,0,1,...:
  - No window lost or duplicated.
  - win_data stable while stalled.
  - bram_en never issues while pending is full.
- base_addr=0xFFE with 4x4 image: addresses wrap to 0x000.. and windows match wrapped data.
- Reset asserted at cycle 10 of a 16x16 frame:
  - All outputs 0 immediately; no done.
  - New start gives 196 correct windows.
- start pulsed again while busy: ignored; window count and done timing unchanged.
- STRIDE2_EN, 6x6 image: exactly 4 windows at (0,0),(0,2),(2,0),(2,2) with correct contents.
